// File: rtl/button_debounce_reader_pkg.sv
// Shared definitions for the push-button reader: per-channel FSM state encoding,
// default timing constants and a small popcount helper.
package button_debounce_reader_pkg;

    typedef enum logic [1:0] {
        ST_UP        = 2'd0,
        ST_DOWN_WAIT = 2'd1,
        ST_DOWN      = 2'd2,
        ST_UP_WAIT   = 2'd3
    } btn_state_e;

    localparam int         DEF_NBTN          = 4;
    localparam int         DEF_SYNC_STAGES   = 2;
    localparam int         DEF_DEBOUNCE_BITS = 18;
    localparam int         DEF_LONG_BITS     = 23;
    localparam logic [3:0] DEF_ACTIVE_LOW    = 4'b0001;

    // Number of set bits in a (zero-extended) event vector; fits 8 bits for <=32 channels.
    function automatic logic [7:0] count_ones(input logic [31:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce FSM with stable-time counter,
// long-press hold counter and registered single-cycle event pulses.
module btn_debounce_ch
    import button_debounce_reader_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_BITS = DEF_DEBOUNCE_BITS,
    parameter int LONG_BITS     = DEF_LONG_BITS
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic norm,
    output logic btn_state,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam logic [DEBOUNCE_BITS-1:0] DC_MAX = '1;
    localparam logic [LONG_BITS-1:0]     LC_MAX = '1;

    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     s;
    btn_state_e               state_q, state_d;
    logic [DEBOUNCE_BITS-1:0] dc_q, dc_d;
    logic [LONG_BITS-1:0]     lc_q, lc_d;
    logic                     long_done_q, long_done_d;
    logic                     level_d, press_d, release_d, long_d;

    // NOTE: the synchroniser resets to the normalised idle level (0), so reset release
    // with an idle pin never looks like an edge; a held pin still gets a full debounce.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
            sync_q <= {sync_q[SYNC_STAGES-2:0], norm};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_UP;
            dc_q        <= '0;
            lc_q        <= '0;
            long_done_q <= 1'b0;
            btn_state   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_long    <= 1'b0;
        end else begin
            state_q     <= state_d;
            dc_q        <= dc_d;
            lc_q        <= lc_d;
            long_done_q <= long_done_d;
            btn_state   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
            btn_long    <= long_d;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves a latch.
        state_d     = state_q;
        dc_d        = dc_q;
        lc_d        = lc_q;
        long_done_d = long_done_q;
        level_d     = btn_state;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        unique case (state_q)
            ST_UP: begin
                if (s) begin
                    state_d     = ST_DOWN_WAIT;
                    dc_d        = '0;
                    lc_d        = '0;
                    long_done_d = 1'b0;
                end
            end
            ST_DOWN_WAIT: begin
                if (!s) begin
                    state_d = ST_UP;
                end else begin
                    dc_d = dc_q + 1'b1;
                    if (dc_q == DC_MAX) begin
                        state_d = ST_DOWN;
                        press_d = 1'b1;
                        level_d = 1'b1;
                    end
                end
            end
            ST_DOWN: begin
                // Hold counter saturates; the done flag makes the long pulse one-shot per press.
                if (lc_q != LC_MAX) begin
                    lc_d = lc_q + 1'b1;
                end else if (!long_done_q) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end
                if (!s) begin
                    state_d = ST_UP_WAIT;
                    dc_d    = '0;
                end
            end
            ST_UP_WAIT: begin
                if (s) begin
                    state_d = ST_DOWN;
                end else begin
                    dc_d = dc_q + 1'b1;
                    if (dc_q == DC_MAX) begin
                        state_d   = ST_UP;
                        release_d = 1'b1;
                        level_d   = 1'b0;
                    end
                end
            end
            default: state_d = ST_UP;
        endcase
    end

endmodule

// File: rtl/button_debounce_reader.sv
// Board button reader: polarity normalisation, one debounce channel per pin and a
// running press-event counter shared by all channels.
module button_debounce_reader
    import button_debounce_reader_pkg::*;
#(
    parameter int              NBTN          = DEF_NBTN,
    parameter int              SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int              DEBOUNCE_BITS = DEF_DEBOUNCE_BITS,
    parameter int              LONG_BITS     = DEF_LONG_BITS,
    parameter logic [NBTN-1:0] ACTIVE_LOW    = NBTN'(DEF_ACTIVE_LOW)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [NBTN-1:0] BTN_IN,
    output logic [NBTN-1:0] BTN_STATE,
    output logic [NBTN-1:0] BTN_PRESS,
    output logic [NBTN-1:0] BTN_RELEASE,
    output logic [NBTN-1:0] BTN_LONG,
    output logic [7:0]      EVT_COUNT
);

    logic [NBTN-1:0] norm;
    logic [31:0]     press_ext;
    logic [7:0]      evt_add;

    assign norm = BTN_IN ^ ACTIVE_LOW;

    for (genvar i = 0; i < NBTN; i++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE_BITS(DEBOUNCE_BITS),
            .LONG_BITS    (LONG_BITS)
        ) u_ch (
            .CLK        (CLK),
            .RST_N      (RST_N),
            .norm       (norm[i]),
            .btn_state  (BTN_STATE[i]),
            .btn_press  (BTN_PRESS[i]),
            .btn_release(BTN_RELEASE[i]),
            .btn_long   (BTN_LONG[i])
        );
    end

    assign press_ext = 32'(BTN_PRESS);
    assign evt_add   = count_ones(press_ext);

    // Counts every press bit of the cycle; wraps modulo 256 by design.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            EVT_COUNT <= '0;
        end else begin
            EVT_COUNT <= EVT_COUNT + evt_add;
        end
    end

endmodule

// File: tb/tb_button_debounce_reader.sv
// Self-checking bench for button_debounce_reader: constant vector table, hand-written
// corner sequences and randomised pin activity checked against a behavioural model.
module tb_button_debounce_reader;

    localparam logic [3:0] AL         = 4'b0001;
    localparam logic [3:0] IDLE       = 4'b0001;
    localparam int         STABLE     = (1 << 4) + 1;  // consecutive differing samples to flip
    localparam int         LONG_EDGES = 1 << 6;        // edges spent settled-down before long

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic [3:0] BTN_IN = IDLE;
    logic [3:0] BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_LONG;
    logic [7:0] EVT_COUNT;

    button_debounce_reader #(
        .NBTN(4), .SYNC_STAGES(2), .DEBOUNCE_BITS(4), .LONG_BITS(6), .ACTIVE_LOW(4'b0001)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .BTN_IN(BTN_IN),
        .BTN_STATE(BTN_STATE), .BTN_PRESS(BTN_PRESS), .BTN_RELEASE(BTN_RELEASE),
        .BTN_LONG(BTN_LONG), .EVT_COUNT(EVT_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: a level flips after STABLE consecutive synchronised samples
    // disagree with it; long fires on the 64th edge spent settled in the pressed level.
    logic [1:0] m_sync [4];
    logic [3:0] m_level, m_press, m_rel, m_long;
    int         m_run  [4];
    int         m_down [4];
    logic [7:0] m_evt;

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_sync[c] = 2'b00;
            m_run[c]  = 0;
            m_down[c] = 0;
        end
        m_level = '0; m_press = '0; m_rel = '0; m_long = '0; m_evt = '0;
    endtask

    task automatic model_step(input logic [3:0] in);
        logic [3:0] norm, np, nr, nl;
        norm = in ^ AL;
        np = '0; nr = '0; nl = '0;
        m_evt = m_evt + 8'($countones(m_press));
        for (int c = 0; c < 4; c++) begin
            logic s;
            s = m_sync[c][1];
            if (m_level[c] && m_run[c] == 0) begin
                m_down[c]++;
                if (m_down[c] == LONG_EDGES) nl[c] = 1'b1;
            end
            if (s != m_level[c]) begin
                m_run[c]++;
                if (m_run[c] == STABLE) begin
                    m_level[c] = s;
                    m_run[c]   = 0;
                    if (s) begin
                        np[c]     = 1'b1;
                        m_down[c] = 0;
                    end else begin
                        nr[c] = 1'b1;
                    end
                end
            end else begin
                m_run[c] = 0;
            end
            m_sync[c] = {m_sync[c][0], norm[c]};
        end
        m_press = np; m_rel = nr; m_long = nl;
    endtask

    // Drive pins 1 unit after an edge, advance one clock, then compare against the model.
    task automatic cycle(input logic [3:0] in);
        BTN_IN = in;
        @(posedge CLK);
        if (!RST_N) model_reset();
        else        model_step(in);
        #1;
        check("model", 32'({BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_LONG, EVT_COUNT}),
                       32'({m_level, m_press, m_rel, m_long, m_evt}));
    endtask

    typedef struct {
        logic [3:0] in;
        int         cycles;
        logic [3:0] exp_state;
        logic [7:0] exp_evt;
        int         exp_events;    // press+release bits pulsed during the record
        int         exp_first;     // edge of first press/release pulse, 0 = none
        int         exp_max_pop;   // most press+release bits in a single cycle
        int         exp_long_edge; // edge of the long pulse, 0 = none
    } vec_t;

    vec_t vecs [7];

    task automatic run_vector(input int idx, input vec_t v);
        int first_edge, n_events, max_pop, long_edge, n_long, pop;
        first_edge = 0; n_events = 0; max_pop = 0; long_edge = 0; n_long = 0;
        for (int e = 1; e <= v.cycles; e++) begin
            cycle(v.in);
            pop = $countones(BTN_PRESS) + $countones(BTN_RELEASE);
            n_events += pop;
            if (pop > max_pop) max_pop = pop;
            if (pop != 0 && first_edge == 0) first_edge = e;
            if (BTN_LONG != '0) begin
                n_long += $countones(BTN_LONG);
                if (long_edge == 0) long_edge = e;
            end
        end
        check($sformatf("vec%0d_state", idx), 32'(BTN_STATE), 32'(v.exp_state));
        check($sformatf("vec%0d_evt", idx), 32'(EVT_COUNT), 32'(v.exp_evt));
        check($sformatf("vec%0d_events", idx), n_events, v.exp_events);
        check($sformatf("vec%0d_first_edge", idx), first_edge, v.exp_first);
        check($sformatf("vec%0d_max_pop", idx), max_pop, v.exp_max_pop);
        check($sformatf("vec%0d_long_edge", idx), long_edge, v.exp_long_edge);
        check($sformatf("vec%0d_long_count", idx), n_long, (v.exp_long_edge != 0) ? 1 : 0);
    endtask

    function automatic int pick_hold();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 50)      return int'($urandom_range(1, 8));
        else if (r < 85) return int'($urandom_range(15, 40));
        else             return int'($urandom_range(60, 120));
    endfunction

    task automatic random_phase(input int n_cycles);
        logic [3:0] raw;
        int         hold [4];
        raw = IDLE;
        for (int c = 0; c < 4; c++) hold[c] = pick_hold();
        for (int i = 0; i < n_cycles; i++) begin
            for (int c = 0; c < 4; c++) begin
                hold[c]--;
                if (hold[c] == 0) begin
                    raw[c]  = ~raw[c];
                    hold[c] = pick_hold();
                end
            end
            cycle(raw);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_edge, n_events, n_rel_before;

        vecs[0] = '{IDLE,    10,  4'b0000, 8'd0, 0, 0,  0, 0};
        vecs[1] = '{4'b0011, 30,  4'b0010, 8'd1, 1, 19, 1, 0};
        vecs[2] = '{IDLE,    30,  4'b0000, 8'd1, 1, 19, 1, 0};
        vecs[3] = '{4'b0000, 100, 4'b0001, 8'd2, 1, 19, 1, 83};
        vecs[4] = '{IDLE,    30,  4'b0000, 8'd2, 1, 19, 1, 0};
        vecs[5] = '{4'b1111, 30,  4'b1110, 8'd5, 3, 19, 3, 0};
        vecs[6] = '{IDLE,    30,  4'b0000, 8'd5, 3, 19, 3, 0};

        model_reset();
        repeat (3) cycle(IDLE);
        check("reset_state", 32'({BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_LONG, EVT_COUNT}), 32'd0);
        RST_N = 1'b1;

        for (int v = 0; v < 7; v++) run_vector(v, vecs[v]);

        // Bounce on channel 2: toggles every 3 cycles never settle long enough.
        n_events = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(((i / 3) % 2 == 0) ? (IDLE | 4'b0100) : IDLE);
            n_events += $countones(BTN_PRESS | BTN_RELEASE | BTN_LONG);
        end
        for (int i = 0; i < 30; i++) begin
            cycle(IDLE);
            n_events += $countones(BTN_PRESS | BTN_RELEASE | BTN_LONG);
        end
        check("bounce_pulses", n_events, 0);
        check("bounce_evt", 32'(EVT_COUNT), 32'd5);
        check("bounce_state", 32'(BTN_STATE), 32'd0);

        // Reset asserted mid-hold clears outputs without a clock edge.
        repeat (40) cycle(4'b0011);
        check("hold_state", 32'(BTN_STATE), 32'b0010);
        #2 RST_N = 1'b0;
        #1;
        check("async_clear", 32'({BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_LONG, EVT_COUNT}), 32'd0);
        model_reset();
        repeat (3) cycle(4'b0011);
        RST_N = 1'b1;

        // Button held through reset release: one fresh press after the full latency.
        first_edge = 0; n_events = 0; n_rel_before = 0;
        for (int e = 1; e <= 40; e++) begin
            cycle(4'b0011);
            if (BTN_RELEASE != '0 && first_edge == 0) n_rel_before++;
            if (BTN_PRESS != '0) begin
                n_events += $countones(BTN_PRESS);
                if (first_edge == 0) first_edge = e;
            end
        end
        check("held_reset_press_edge", first_edge, 19);
        check("held_reset_press_count", n_events, 1);
        check("held_reset_no_release", n_rel_before, 0);
        check("held_reset_evt", 32'(EVT_COUNT), 32'd1);
        repeat (30) cycle(IDLE);

        random_phase(3000);

        // Counter wrap: preload to 254 through presses, then three more presses.
        RST_N = 1'b0;
        repeat (2) cycle(IDLE);
        RST_N = 1'b1;
        for (int r = 0; r < 84; r++) begin
            repeat (20) cycle(4'b1111);
            repeat (20) cycle(IDLE);
        end
        repeat (20) cycle(4'b0111);
        repeat (20) cycle(IDLE);
        check("evt_preload", 32'(EVT_COUNT), 32'd254);
        repeat (20) cycle(4'b1111);
        check("evt_wrap", 32'(EVT_COUNT), 32'd1);
        repeat (20) cycle(IDLE);
        check("final_state", 32'(BTN_STATE), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
